// File: rtl/instr_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_queue
// Purpose  : Prefetching instruction fetch stage. Streams 16-bit words from
//            the program RAM read port (port B) and pairs them into
//            {op, regnum, num} instructions. Holds up to DEPTH instructions
//            in a FIFO that decode drains with a valid/ready handshake.
//            A redirect flushes the queue and restarts fetch at redirect_pc.
// Ports    : clkb        - clock, shared with RAM port B
//            rst         - synchronous active-high reset
//            enb/addrb   - RAM port-B read enable / word address
//            dob         - RAM read data, valid the cycle after the issue
//            redirect    - flush and restart fetch at redirect_pc (even)
//            out_valid   - head instruction available
//            out_ready   - decode accepts the head
//            out_op      - head word0[15:8]
//            out_regnum  - head word0[7:0]
//            out_num     - head word1
//            out_pc      - head word0 address (only with FETCH_PC_OUT_EN)
// Options  : FETCH_PC_OUT_EN - store the word0 address per entry and
//            present it on out_pc.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 10
) (
    input  logic          clkb,
    input  logic          rst,
    output logic          enb,
    output logic [AW-1:0] addrb,
    input  logic [15:0]   dob,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_pc,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7:0]    out_op,
    output logic [7:0]    out_regnum,
    output logic [15:0]   out_num
`ifdef FETCH_PC_OUT_EN
    ,
    output logic [AW-1:0] out_pc
`endif
);

    localparam int c_PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CW = c_PW + 1;
    localparam logic [c_CW:0] c_DEPTH = (c_CW + 1)'(DEPTH);

    // Fetch-side state
    logic [AW-1:0]   r_pc;
    logic            r_phase;         // 0: next issue is word0, 1: word1
    logic            r_resp_pending;  // a word was issued last cycle
    logic            r_resp_phase;    // which word is returning on dob
    logic [7:0]      r_hold_op;
    logic [7:0]      r_hold_reg;
    logic            r_open;          // word0 issued, instruction not yet pushed

    // FIFO state
    logic [31:0]     r_mem_data [DEPTH];
    logic [c_PW-1:0] r_wr_ptr;
    logic [c_PW-1:0] r_rd_ptr;
    logic [c_CW-1:0] r_count;

`ifdef FETCH_PC_OUT_EN
    logic [AW-1:0]   r_word0_pc;
    logic [AW-1:0]   r_mem_pc [DEPTH];
`endif

    logic [c_CW:0]   w_reserved;
    logic            w_issue;
    logic            w_push;
    logic            w_pop;
    logic [31:0]     w_head;

    // A started instruction reserves its FIFO slot, so pushes can never
    // overflow. Pops in the current cycle are deliberately not credited.
    always_comb begin
        w_reserved = {1'b0, r_count} + {{c_CW{1'b0}}, r_open};
        enb        = !rst && !redirect && (r_phase || (w_reserved < c_DEPTH));
        addrb      = r_pc;
    end

    always_comb begin
        w_issue   = enb;
        w_push    = r_resp_pending && r_resp_phase;
        out_valid = (r_count != '0);
        w_pop     = out_valid && out_ready;
        w_head    = r_mem_data[r_rd_ptr];
        // Gating with out_valid keeps the outputs at zero while empty,
        // independent of whatever the unreset storage holds.
        out_op     = out_valid ? w_head[31:24] : 8'h00;
        out_regnum = out_valid ? w_head[23:16] : 8'h00;
        out_num    = out_valid ? w_head[15:0]  : 16'h0000;
`ifdef FETCH_PC_OUT_EN
        out_pc     = out_valid ? r_mem_pc[r_rd_ptr] : '0;
`endif
    end

    always_ff @(posedge clkb) begin
        if (rst) begin
            r_pc           <= '0;
            r_phase        <= 1'b0;
            r_resp_pending <= 1'b0;
            r_resp_phase   <= 1'b0;
            r_hold_op      <= 8'h00;
            r_hold_reg     <= 8'h00;
            r_open         <= 1'b0;
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
`ifdef FETCH_PC_OUT_EN
            r_word0_pc     <= '0;
`endif
        end else if (redirect) begin
            // Returning word is dropped and any same-cycle push/pop ignored.
            r_pc           <= redirect_pc;
            r_phase        <= 1'b0;
            r_resp_pending <= 1'b0;
            r_resp_phase   <= 1'b0;
            r_open         <= 1'b0;
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
        end else begin
            r_resp_pending <= w_issue;
            if (w_issue) begin
                r_pc         <= r_pc + AW'(1);
                r_phase      <= ~r_phase;
                r_resp_phase <= r_phase;
            end
`ifdef FETCH_PC_OUT_EN
            if (w_issue && !r_phase) begin
                r_word0_pc <= r_pc;
            end
`endif
            if (r_resp_pending && !r_resp_phase) begin
                r_hold_op  <= dob[15:8];
                r_hold_reg <= dob[7:0];
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
            // A new word0 can issue in the same cycle the previous
            // instruction completes; the new reservation takes precedence.
            if (w_issue && !r_phase) begin
                r_open <= 1'b1;
            end else if (w_push) begin
                r_open <= 1'b0;
            end
        end
    end

    // FIFO storage: no reset needed, contents are only visible via count.
    always_ff @(posedge clkb) begin
        if (!rst && !redirect && w_push) begin
            r_mem_data[r_wr_ptr] <= {r_hold_op, r_hold_reg, dob};
`ifdef FETCH_PC_OUT_EN
            r_mem_pc[r_wr_ptr]   <= r_word0_pc;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_queue
// Purpose  : Self-checking bench for instr_fetch_queue. A RAM model feeds
//            port B; stimulus pushes the expected instruction stream into a
//            scoreboard on every reset/redirect, and a monitor checks fetch
//            addresses, read-enable throttling, latency and output content.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 10;

    logic          clkb = 1'b0;
    logic          rst = 1'b1;
    logic          enb;
    logic [AW-1:0] addrb;
    logic [15:0]   dob = 16'h0000;
    logic          redirect = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [7:0]    out_op;
    logic [7:0]    out_regnum;
    logic [15:0]   out_num;
`ifdef FETCH_PC_OUT_EN
    logic [AW-1:0] out_pc;
`endif

    instr_fetch_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clkb        (clkb),
        .rst         (rst),
        .enb         (enb),
        .addrb       (addrb),
        .dob         (dob),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_op      (out_op),
        .out_regnum  (out_regnum),
        .out_num     (out_num)
`ifdef FETCH_PC_OUT_EN
        ,
        .out_pc      (out_pc)
`endif
    );

    always #5 clkb = ~clkb;

    // Program RAM port B model: registered read.
    logic [15:0] ram [1 << AW];
    always @(posedge clkb) begin
        if (enb) dob <= ram[addrb];
    end

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [7:0]    op;
        logic [7:0]    rg;
        logic [15:0]   num;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference stream: instruction k after a restart at 'start' is the word
    // pair at start+2k, start+2k+1 (addresses modulo the RAM size).
    task automatic expect_stream(input logic [AW-1:0] start);
        logic [AW-1:0] a;
        exp_t e;
        exp_q.delete();
        for (int k = 0; k < (1 << (AW - 1)); k++) begin
            a     = start + AW'(2 * k);
            e.pc  = a;
            e.op  = ram[a][15:8];
            e.rg  = ram[a][7:0];
            e.num = ram[a + AW'(1)];
            exp_q.push_back(e);
        end
    endtask

    // ---------------- monitor ----------------
    int            since = 0;
    int            w0_cnt = 0;
    int            pop_cnt = 0;
    int            reads = 0;
    int            total_pops = 0;
    bit            par = 0;
    bit            seen_valid = 0;
    bit            hold_v = 0;
    bit            prev_rst = 0;
    bit            w1_issue = 0;
    logic [AW-1:0] exp_addr = '0;
    logic [31:0]   held = '0;
    logic [AW-1:0] held_pc = '0;

    always @(negedge clkb) begin
        logic [AW-1:0] cur_pc;
        logic          exp_enb;
        exp_t          e;
`ifdef FETCH_PC_OUT_EN
        cur_pc = out_pc;
`else
        cur_pc = '0;
`endif
        w1_issue = 0;
        if (rst || redirect) begin
            check("enb_off_in_flush", {63'd0, enb}, 64'd0);
            if (rst && prev_rst)
                check("reset_state", {enb, addrb, out_valid, out_op, out_regnum, out_num, cur_pc},
                      64'd0);
            exp_addr   = rst ? '0 : redirect_pc;
            par        = 0;
            w0_cnt     = 0;
            pop_cnt    = 0;
            reads      = 0;
            since      = -1;
            seen_valid = 0;
            hold_v     = 0;
        end else begin
            since++;
            if (since == 0) check("valid_after_restart", {63'd0, out_valid}, 64'd0);
            // A word1 is always due right after word0; a new word0 needs a
            // free slot among instructions started but not yet consumed.
            exp_enb = par || ((w0_cnt - pop_cnt) < DEPTH);
            check("enb", {63'd0, enb}, {63'd0, exp_enb});
            if (enb) begin
                check("addrb", {54'd0, addrb}, {54'd0, exp_addr});
                exp_addr = exp_addr + AW'(1);
                reads++;
                if (!par) w0_cnt++;
                w1_issue = par;
                par      = !par;
            end
            if (out_valid && !seen_valid) begin
                check("first_latency", since, 3);
                seen_valid = 1;
            end
            if (hold_v)
                check("stall_stable", {out_valid, cur_pc, out_op, out_regnum, out_num},
                      {1'b1, held_pc, held});
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("sb_empty", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("instr", {32'd0, out_op, out_regnum, out_num}, {32'd0, e.op, e.rg, e.num});
`ifdef FETCH_PC_OUT_EN
                    check("out_pc", {54'd0, out_pc}, {54'd0, e.pc});
`endif
                end
                pop_cnt++;
                total_pops++;
            end
            hold_v  = out_valid && !out_ready;
            held    = {out_op, out_regnum, out_num};
            held_pc = cur_pc;
        end
        prev_rst = rst;
    end

    // ---------------- stimulus ----------------
    task automatic do_reset(input int n);
        rst = 1'b1;
        expect_stream('0);
        repeat (n) @(posedge clkb);
        #1 rst = 1'b0;
    endtask

    task automatic do_redirect(input logic [AW-1:0] pc);
        redirect    = 1'b1;
        redirect_pc = pc;
        expect_stream(pc);
        @(posedge clkb);
        #1 redirect = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(posedge clkb);
            #1;
        end
    endtask

    initial begin
        bit found;
        for (int i = 0; i < (1 << AW); i++) ram[i] = 16'($urandom);
        ram[0] = 16'h0401; ram[1] = 16'h0005; ram[2] = 16'h0502; ram[3] = 16'h0003;
        ram[4] = 16'h0603; ram[5] = 16'h0001; ram[6] = 16'h0100; ram[7] = 16'h0000;

        // Streaming from reset with decode always ready.
        out_ready = 1'b1;
        do_reset(3);
        run(12);

        // Full stall: only DEPTH instructions (8 words) may be fetched.
        out_ready = 1'b0;
        do_reset(2);
        run(20);
        check("stall_reads", reads, 8);
        check("stall_valid", {63'd0, out_valid}, 64'd1);
        out_ready = 1'b1;
        run(12);

        // Reset mid-stream with three entries buffered.
        out_ready = 1'b0;
        do_reset(2);
        run(7);
        do_reset(2);
        out_ready = 1'b1;
        run(10);

        // Redirect while a word1 response is returning.
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clkb);
            found = w1_issue;
        end
        check("w1_wait", {63'd0, found}, 64'd1);
        @(posedge clkb);
        #1;
        do_redirect(10'h100);
        run(10);

        // Back-to-back redirects, last wins; then wrap past the top address.
        do_redirect(10'h200);
        do_redirect(10'h3FE);
        run(10);

        do_redirect(10'h010);
        run(10);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            int r;
            out_ready = 1'($urandom % 2);
            r = int'($urandom % 1000);
            if (r < 20) do_redirect(AW'(2 * $urandom_range(0, (1 << (AW - 1)) - 1)));
            else if (r < 25) do_reset(1 + int'($urandom % 2));
            else run(1);
        end
        out_ready = 1'b1;
        run(10);

        check("liveness", {63'd0, total_pops > 100}, 64'd1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_fetch_queue.md
# instr_fetch_queue

Prefetching instruction fetch stage between the dual-port program RAM's read port (port B) and the decode/execute stage. It streams 16-bit words from RAM, assembles each pair into one instruction {op, regnum, address/num}, and buffers up to DEPTH decoded-ready instructions in a FIFO. Decode consumes them through a valid/ready handshake. A redirect input (jump, loop-back, interrupt) flushes the queue and restarts fetch at a new address.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- AW, 10, RAM word-address width
- clkb  in  1  clock; same clock as RAM port B
- rst  in  1  synchronous, active-high reset
- enb  out  1  RAM port-B read enable
- addrb  out  AW  RAM port-B word address
- dob  in  16  RAM read data; valid the cycle after the enb/addrb issue cycle
- redirect  in  1  flush and restart fetch at redirect_pc
- redirect_pc  in  AW  new fetch address; must be even-aligned to an instruction's first word
- out_valid  out  1  head instruction available
- out_ready  in  1  decode accepts head
- out_op  out  8  head word0[15:8]
- out_regnum  out  8  head word0[7:0]
- out_num  out  16  head word1
- out_pc  out  AW  address of head word0; present only with FETCH_PC_OUT_EN

## Operation
- State:
  - pc: next word address to issue.
  - phase: 0 = next issue is word0, 1 = word1.
  - resp_pending: a word was issued last cycle.
  - resp_phase: which word is returning.
  - hold_op/hold_reg: captured word0.
  - FIFO with count 0..DEPTH.
  - open: 0/1; word0 issued, instruction not yet pushed.
- enb/addrb are combinational from state:
  - enb = !rst && !redirect && (phase==1 || count+open < DEPTH).
  - addrb = pc.
  - Pops in the current cycle are not credited; the reservation rule is conservative.
- On issue: pc <= pc+1, wrapping modulo 2^AW. phase toggles. Issuing word0 sets open.
- Word1 is always issued the cycle immediately after word0 unless redirect intervenes.
- Response cycle (resp_pending):
  - resp_phase 0: capture dob into hold_op/hold_reg.
  - resp_phase 1: push {hold_op, hold_reg, dob, pc_of_word0} and clear open.
- Pop when out_valid && out_ready. Push and pop in the same cycle: count unchanged.
- Push while full cannot occur because of the reservation rule. The bench asserts this.
- out_* fields are the FIFO head; they hold stable while out_valid && !out_ready.
- Redirect has highest priority. On the clock edge where it is sampled:
  - count<=0, open<=0, phase<=0, pc<=redirect_pc.
  - The pending response is discarded: the returning word is neither captured nor pushed.
  - Any same-cycle pop or push is ignored.
- Back-to-back redirects: the last one wins; no fetch occurs in between.
- Reset: pc=0, phase=0, count=0, open=0, resp_pending=0. Outputs: enb=0, addrb=0, out_valid=0, out_op=0, out_regnum=0, out_num=0, out_pc=0.

## Timing
- Cycle C0 = first cycle with rst low.
  - C0: enb=1, addrb=0.
  - C1: addrb=1.
  - End of C1: word0 captured.
  - End of C2: push.
  - C3: out_valid=1.
- First-instruction latency: 3 cycles after reset release or after redirect.
- Steady-state throughput: one instruction per 2 cycles.
- A stall never drops data. With out_ready=0, fetch stops once count+open == DEPTH.
- After a pop, issue resumes in the next cycle.
- Redirect sampled at edge E:
  - out_valid=0 and enb=1 with addrb=redirect_pc in the cycle after E.
  - First redirected instruction is visible 3 cycles after E.
- Addresses wrap: after 2^AW−1, fetch continues at 0.

## Configuration
- FETCH_PC_OUT_EN defined:
  - Each FIFO entry also stores the word0 address (AW bits).
  - out_pc port exists and shows the head's address. Decode uses it for relative loop-back targets.
- Undefined: out_pc is absent and the FIFO entry is 32 bits. All other behaviour is identical.

## Test plan
- RAM words 0..7 = 0x0401,0x0005,0x0502,0x0003,0x0603,0x0001,0x0100,0x0000; out_ready=1 → four instructions in order, (04,01,0005), (05,02,0003), (06,03,0001), (01,00,0000), each spaced 2 cycles apart, first out_valid 3 cycles after reset release.
- out_ready=0 for 20 cycles, DEPTH=4 → exactly 8 reads issued (addrs 0..7), count=4, enb=0 thereafter; release ready → entries popped in order, fetch resumes at addr 8 the cycle after the first pop.
- redirect=1, redirect_pc=0x100, pulsed while a word1 response is returning → that instruction is never output; out_valid=0 next cycle; first output is the pair at 0x100/0x101 three cycles later.
- Fetch starting at redirect_pc=0x3FE → instruction from 0x3FE/0x3FF, then addrb wraps to 0x000 and the next instruction comes from 0x000/0x001.
- rst asserted mid-stream with count=3 → next cycle out_valid=0, enb=0, addrb=0; after release fetch restarts at 0.
- FETCH_PC_OUT_EN defined, redirect to 0x010 → out_pc=0x010, then 0x012, 0x014 on successive pops.
